// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state encodings and timing defaults
// used by the hazard controller and its counters.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int WAIT_CNT_W      = 8;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: up-counter that saturates at all-ones instead of wrapping.
// Ports:
//   clk  - clock, rising edge
//   clr  - synchronous clear (wins over inc)
//   inc  - add one this cycle unless already saturated
//   cnt  - current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller. Freezes the whole pipe while a
// data-memory access is outstanding, flushes IF/ID and ID/EX on a taken
// branch, and inserts a one-cycle bubble for load-use hazards.
// Ports:
//   clk, reset                      - clock and synchronous active-high reset
//   ifid_rs1/rs2, ifid_use_rs1/rs2  - ID-stage source registers and use flags
//   idex_rd, idex_memread           - EX-stage destination and load flag
//   branch_taken                    - EX resolved a taken branch/jump
//   dmem_req, dmem_ready            - MEM-stage access outstanding / completing
//   pc/ifid/exmem/memwb_write       - pipeline-register write enables
//   ifid_flush, idex_flush          - bubble insertion
//   stall_cycles, flush_count       - saturating performance counters
//   mem_timeout                     - sticky memory-wait timeout flag
//
// state    | meaning
// RUN      | pipeline flowing; outputs from branch/load-use/normal rules
// MEM_WAIT | data access pending; pipe frozen until dmem_ready (or forever after timeout)
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_use_rs1,
  input  logic             ifid_use_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_memread,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(TIMEOUT);

  hz_state_e             state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  mem_timeout_q, mem_timeout_d;

  logic load_use;
  logic freeze;
  logic timeout_hit;
  logic stall_inc;
  logic flush_inc;

  assign load_use = idex_memread && (idex_rd != 5'd0) &&
                    ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                     (ifid_use_rs2 && (ifid_rs2 == idex_rd)));

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    freeze        = 1'b0;
    timeout_hit   = (state_q == MEM_WAIT) && (wait_cnt_q == TIMEOUT_CNT);

    unique case (state_q)
      RUN: begin
        // ready in the same cycle as the request completes the access at once
        if (dmem_req && !dmem_ready) begin
          freeze     = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        // once timed out, a late dmem_ready no longer releases the pipe
        if (mem_timeout_q || timeout_hit || !dmem_ready) begin
          freeze = 1'b1;
          if (wait_cnt_q != '1) begin
            wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
          end
        end else begin
          state_d = RUN;
        end
        if (timeout_hit) begin
          mem_timeout_d = 1'b1;
        end
      end
    endcase

    if (reset) begin
      state_d       = RUN;
      wait_cnt_d    = '0;
      mem_timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q       <= state_d;
    wait_cnt_q    <= wait_cnt_d;
    mem_timeout_q <= mem_timeout_d;
  end

  // The release cycle out of MEM_WAIT has freeze=0 and so falls through to
  // the RUN priority chain below; a branch held in EX during the freeze
  // is applied there.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign stall_inc   = !reset && (freeze || (!branch_taken && load_use));
  assign flush_inc   = !reset && !freeze && branch_taken;
  assign mem_timeout = mem_timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (reset),
    .inc (stall_inc),
    .cnt (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (reset),
    .inc (flush_inc),
    .cnt (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  // {pc_write, ifid_write, exmem_write, memwb_write, ifid_flush, idex_flush}
  localparam logic [5:0] C_NORM = 6'b111100;
  localparam logic [5:0] C_FRZ  = 6'b000000;
  localparam logic [5:0] C_BR   = 6'b111111;
  localparam logic [5:0] C_LU   = 6'b001101;
  localparam logic [5:0] C_RST  = 6'b000011;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       ifid_rs1, ifid_rs2, idex_rd;
  logic             ifid_use_rs1, ifid_use_rs2, idex_memread;
  logic             branch_taken, dmem_req, dmem_ready;
  logic             pc_write, ifid_write, exmem_write, memwb_write;
  logic             ifid_flush, idex_flush;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic             mem_timeout;

  // staged stimulus, applied to the DUT at the next falling edge
  logic       s_reset = 1'b1;
  logic [4:0] s_rs1 = '0, s_rs2 = '0, s_rd = '0;
  logic       s_use1 = 1'b0, s_use2 = 1'b0, s_memread = 1'b0;
  logic       s_branch = 1'b0, s_req = 1'b0, s_ready = 1'b0;

  logic [CNT_W-1:0] m_st = '0;
  logic [CNT_W-1:0] m_fl = '0;
  logic             exp_to = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [5:0]       ctrl;
    logic [CNT_W-1:0] st;
    logic [CNT_W-1:0] fl;
    logic             to;
    string            tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .ifid_rs1     (ifid_rs1),
    .ifid_rs2     (ifid_rs2),
    .ifid_use_rs1 (ifid_use_rs1),
    .ifid_use_rs2 (ifid_use_rs2),
    .idex_rd      (idex_rd),
    .idex_memread (idex_memread),
    .branch_taken (branch_taken),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .exmem_write  (exmem_write),
    .memwb_write  (memwb_write),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
    .mem_timeout  (mem_timeout)
  );

  task automatic apply();
    reset        = s_reset;
    ifid_rs1     = s_rs1;
    ifid_rs2     = s_rs2;
    ifid_use_rs1 = s_use1;
    ifid_use_rs2 = s_use2;
    idex_rd      = s_rd;
    idex_memread = s_memread;
    branch_taken = s_branch;
    dmem_req     = s_req;
    dmem_ready   = s_ready;
  endtask

  // One clock cycle: drive staged inputs, push expectation, sample mid-cycle.
  // Counters observed in a cycle reflect all previous cycles; the model is
  // advanced afterwards according to what this cycle should count.
  task automatic step(input logic [5:0] ec, input string tag);
    exp_t e;
    exp_t got;
    logic [5:0] ctrl;
    @(negedge clk);
    apply();
    e.ctrl = ec; e.st = m_st; e.fl = m_fl; e.to = exp_to; e.tag = tag;
    sb.push_back(e);
    #1;
    got  = sb.pop_front();
    ctrl = {pc_write, ifid_write, exmem_write, memwb_write, ifid_flush, idex_flush};
    compared++;
    assert (ctrl === got.ctrl) else begin
      mismatched++;
      $error("FAIL %s ctrl observed=%b expected=%b", got.tag, ctrl, got.ctrl);
    end
    compared++;
    assert (stall_cycles === got.st) else begin
      mismatched++;
      $error("FAIL %s stall_cycles observed=%0d expected=%0d", got.tag, stall_cycles, got.st);
    end
    compared++;
    assert (flush_count === got.fl) else begin
      mismatched++;
      $error("FAIL %s flush_count observed=%0d expected=%0d", got.tag, flush_count, got.fl);
    end
    compared++;
    assert (mem_timeout === got.to) else begin
      mismatched++;
      $error("FAIL %s mem_timeout observed=%b expected=%b", got.tag, mem_timeout, got.to);
    end
    if (s_reset) begin
      m_st   = '0;
      m_fl   = '0;
      exp_to = 1'b0;
    end else begin
      if ((ec == C_FRZ || ec == C_LU) && m_st != '1) m_st = m_st + 1'b1;
      if (ec == C_BR && m_fl != '1) m_fl = m_fl + 1'b1;
    end
  endtask

  task automatic idle_inputs();
    s_reset = 1'b0; s_rs1 = '0; s_rs2 = '0; s_rd = '0;
    s_use1 = 1'b0; s_use2 = 1'b0; s_memread = 1'b0;
    s_branch = 1'b0; s_req = 1'b0; s_ready = 1'b0;
  endtask

  task automatic do_reset();
    s_reset = 1'b1;
    step(C_RST, "reset");
    idle_inputs();
  endtask

  task automatic set_load_use();
    s_memread = 1'b1; s_rd = 5'd5; s_rs1 = 5'd5; s_use1 = 1'b1;
  endtask

  initial begin
    apply();
    repeat (2) @(posedge clk);

    // reset behaviour and counters cleared
    step(C_RST, "reset_hold");
    idle_inputs();
    step(C_NORM, "normal_after_reset");

    // basic load-use bubble, exactly one counted cycle
    set_load_use();
    step(C_LU, "load_use_rs1");
    idle_inputs();
    step(C_NORM, "after_load_use");

    // no hazard when rd is x0 or rs1 not actually read
    set_load_use(); s_rd = 5'd0; s_rs1 = 5'd0;
    step(C_NORM, "rd_zero");
    set_load_use(); s_use1 = 1'b0;
    step(C_NORM, "rs1_unused");
    idle_inputs(); s_memread = 1'b1; s_rd = 5'd9; s_rs2 = 5'd9; s_use2 = 1'b1;
    step(C_LU, "load_use_rs2");
    s_use2 = 1'b0;
    step(C_NORM, "rs2_unused");

    // branch flush beats load-use
    idle_inputs(); set_load_use(); s_branch = 1'b1;
    step(C_BR, "branch_over_load_use");
    idle_inputs();
    step(C_NORM, "after_branch");

    // memory wait: entry + 3 wait cycles, then release under RUN rules
    do_reset();
    s_req = 1'b1; s_ready = 1'b0;
    step(C_FRZ, "mem_entry");
    for (int i = 0; i < 3; i++) step(C_FRZ, "mem_wait");
    s_ready = 1'b1;
    step(C_NORM, "mem_release");
    idle_inputs();
    step(C_NORM, "stall_is_4");

    // ready together with request: no freeze
    s_req = 1'b1; s_ready = 1'b1;
    step(C_NORM, "req_ready_same_cycle");

    // branch during freeze is held off, then applied in release cycle
    s_req = 1'b1; s_ready = 1'b0; s_branch = 1'b1;
    step(C_FRZ, "branch_in_freeze_entry");
    step(C_FRZ, "branch_in_freeze_wait");
    s_ready = 1'b1;
    step(C_BR, "branch_after_release");
    idle_inputs();
    step(C_NORM, "after_deferred_branch");

    // saturate stall_cycles via a long wait, then more stalls
    s_req = 1'b1; s_ready = 1'b0;
    for (int i = 0; i < 20; i++) step(C_FRZ, "sat_wait");
    s_ready = 1'b1;
    step(C_NORM, "sat_release");
    idle_inputs(); set_load_use();
    step(C_LU, "sat_load_use");
    idle_inputs();
    step(C_NORM, "stall_saturated");

    // saturate flush_count
    s_branch = 1'b1;
    for (int i = 0; i < 17; i++) step(C_BR, "flush_sat");
    idle_inputs();
    step(C_NORM, "flush_saturated");

    // timeout: entry edge clears wait counter; in MEM_WAIT cycle k it holds k,
    // so it equals 255 in the 256th wait cycle and the flag shows from the
    // next one, i.e. step index 257 counting the entry step as 0
    do_reset();
    s_req = 1'b1; s_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      exp_to = (i >= 257);
      step(C_FRZ, "timeout_wait");
    end
    s_ready = 1'b1;
    step(C_FRZ, "stuck_after_timeout");
    step(C_FRZ, "still_stuck");

    // reset mid-MEM_WAIT clears everything and returns to RUN
    do_reset();
    step(C_NORM, "run_after_timeout_reset");
    s_req = 1'b1; s_ready = 1'b0;
    step(C_FRZ, "reentry");
    step(C_FRZ, "reentry_wait");
    do_reset();
    step(C_NORM, "wait_abandoned");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the performance counters.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum number of memory-wait cycles before an error is flagged.
REQ-003 The block SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have port ifid_rs1, ifid_rs2  in  5 each  source registers of the instruction in ID.
REQ-006 The block SHALL have port ifid_use_rs1, ifid_use_rs2  in  1 each  set when the ID instruction actually reads rs1 / rs2.
REQ-007 The block SHALL have port idex_rd  in  5  destination register of the instruction in EX.
REQ-008 The block SHALL have port idex_memread  in  1  set when the EX instruction is a load.
REQ-009 The block SHALL have port branch_taken  in  1  set when EX resolves a taken branch or jump.
REQ-010 The block SHALL have port dmem_req  in  1  set when the MEM stage has a data-memory access outstanding.
REQ-011 The block SHALL have port dmem_ready  in  1  set when data memory completes the access.
REQ-012 The block SHALL have port pc_write, ifid_write, exmem_write, memwb_write  out  1 each  pipeline-register write enables.
REQ-013 The block SHALL have port ifid_flush, idex_flush  out  1 each  insert a bubble into the named register.
REQ-014 The block SHALL have port stall_cycles, flush_count  out  CNT_W each  saturating performance counters.
REQ-015 The block SHALL have port mem_timeout  out  1  sticky error flag.

Function
REQ-016 The block SHALL use a two-state FSM, RUN and MEM_WAIT.
REQ-017 In RUN, if dmem_req=1 and dmem_ready=0, the next state SHALL be MEM_WAIT and the current cycle SHALL be a freeze.
REQ-018 In MEM_WAIT, dmem_ready=1 SHALL return the FSM to RUN on the next edge.
REQ-019 During that release cycle the outputs SHALL be evaluated with RUN rules.
REQ-020 A freeze SHALL drive all four write enables to 0 and both flush outputs to 0.
REQ-021 load_use SHALL be defined as idex_memread & (idex_rd!=0) & ((ifid_use_rs1 & ifid_rs1==idex_rd) | (ifid_use_rs2 & ifid_rs2==idex_rd)).
REQ-022 Priority each cycle SHALL be: freeze > branch flush > load-use stall > normal.
REQ-023 Branch flush SHALL drive pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, exmem_write=1 and memwb_write=1.
REQ-024 Load-use stall SHALL drive pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0, exmem_write=1 and memwb_write=1, lasting exactly 1 cycle per load.
REQ-025 Normal operation SHALL drive all write enables to 1 and both flushes to 0.
REQ-026 Control outputs SHALL be combinational from the current state and inputs, with no added latency.
REQ-027 A branch_taken asserted during a freeze SHALL be ignored while frozen and applied in the first non-frozen cycle, because EX holds its value.
REQ-028 stall_cycles SHALL increment by 1 on every freeze or load-use cycle and saturate at all-ones (no wrap).
REQ-029 flush_count SHALL increment by 1 on every branch-flush cycle and saturate at all-ones.
REQ-030 An 8-bit wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle.
REQ-031 If the wait counter reaches TIMEOUT while in MEM_WAIT, mem_timeout SHALL set and remain set until reset.
REQ-032 The FSM SHALL remain in MEM_WAIT after a timeout; recovery is by reset only.
REQ-033 dmem_ready arriving in the same cycle as dmem_req (RUN) SHALL cause no freeze.

Reset
REQ-034 While reset=1, the state SHALL go to RUN on the edge.
REQ-035 While reset=1, the wait counter, stall_cycles, flush_count and mem_timeout SHALL be 0 after the edge.
REQ-036 While reset=1, pc_write, ifid_write, exmem_write and memwb_write SHALL be 0.
REQ-037 While reset=1, ifid_flush and idex_flush SHALL be 1.
REQ-038 A reset asserted mid-MEM_WAIT SHALL abandon the wait immediately, with no counter increment in that cycle.

Structure
REQ-039 State encodings (RUN=1'b0, MEM_WAIT=1'b1) and the TIMEOUT default SHALL live in the shared pipeline-control defines file used by the control modules.
REQ-040 One sub-module, sat_counter (parameterised width, inc input, synchronous clear), SHALL be instantiated twice, for stall_cycles and flush_count.

Verification
REQ-041 Stimulus: idex_memread=1, idex_rd=5, ifid_rs1=5, ifid_use_rs1=1. Required response: one cycle with pc_write=0, ifid_write=0, idex_flush=1, and stall_cycles 0->1.
REQ-042 Stimulus: same as REQ-041 but idex_rd=0, or ifid_use_rs1=0. Required response: no stall, and all write enables 1.
REQ-043 Stimulus: branch_taken=1 together with load_use=1. Required response: branch flush wins, ifid_flush=idex_flush=1, pc_write=1, and flush_count increments while stall_cycles does not.
REQ-044 Stimulus: dmem_req=1 with dmem_ready held 0 for 3 cycles, then 1. Required response: 4 freeze cycles (entry plus 3 in MEM_WAIT), then RUN, and stall_cycles=4.
REQ-045 Stimulus: dmem_ready held 0 for more than 255 cycles. Required response: mem_timeout=1 and stays 1; reset clears it and returns the FSM to RUN.
REQ-046 Stimulus: preload stall_cycles to all-ones via a long wait with CNT_W=4, then apply further stalls. Required response: the counter stays at 4'hF.
